// File: rtl/spi_cmd_ram_v2.sv
// Single-port command RAM behind the SPI slave.
// Decodes 2-bit command prefixes into address loads, writes and held reads.
module spi_cmd_ram_v2 #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int AUTO_INC  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [DATA_W+1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              err
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [1:0] C_WA = 2'b00;
  localparam logic [1:0] C_WD = 2'b01;
  localparam logic [1:0] C_RA = 2'b10;
  localparam logic [1:0] C_RD = 2'b11;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);

  state_t state;

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  logic [1:0]        cmd;
  logic [DATA_W-1:0] payload;
  logic              accept;
  logic              wr_ok;
  logic              rd_ok;
  logic              inc;

  assign cmd      = din[DATA_W+1:DATA_W];
  assign payload  = din[DATA_W-1:0];
  assign rx_ready = !rst && !tx_valid;
  assign accept   = rx_valid && rx_ready;
  assign wr_ok    = {1'b0, wr_addr} < DEPTH;
  assign rd_ok    = {1'b0, rd_addr} < DEPTH;
  assign inc      = (AUTO_INC != 0);

  function automatic logic [ADDR_W-1:0] next_addr(
    input logic [ADDR_W-1:0] a
  );
    return (a == LAST) ? '0 : a + ADDR_W'(1);
  endfunction

  // Storage has no reset; only the write port touches it.
  always_ff @(posedge clk) begin
    if (accept && cmd == C_WD && wr_ok)
      mem[wr_addr] <= payload;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      dout     <= '0;
      tx_valid <= 1'b0;
      err      <= 1'b0;
      wr_addr  <= '0;
      rd_addr  <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (cmd)
              C_WA: wr_addr <= payload[ADDR_W-1:0];
              C_WD: begin
                if (!wr_ok)
                  err <= 1'b1;
                else if (inc)
                  wr_addr <= next_addr(wr_addr);
              end
              C_RA: rd_addr <= payload[ADDR_W-1:0];
              C_RD: begin
                state    <= HOLD;
                tx_valid <= 1'b1;
                if (!rd_ok) begin
                  dout <= '0;
                  err  <= 1'b1;
                end else begin
                  dout <= mem[rd_addr];
                  if (inc)
                    rd_addr <= next_addr(rd_addr);
                end
              end
              default: ;
            endcase
          end
        end
        HOLD: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_ram_v2.sv
// Bench for spi_cmd_ram_v2: a default instance and a depth-200 static one.
// Read data and err pulses are checked by a scoreboard monitor.
module tb_spi_cmd_ram_v2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid [2];
  logic [9:0] din      [2];
  logic       tx_ready [2];
  logic       rx_ready [2];
  logic [7:0] dout     [2];
  logic       tx_valid [2];
  logic       err      [2];

  int checks = 0;
  int failures = 0;
  int unsigned ncyc = 0;
  bit mon_en = 0;

  logic [7:0]  eq [2][16];
  int          wp [2];
  int          rp [2];
  int unsigned ed [2][16];
  int          ewp [2];
  int          erp [2];

  always #5 clk = ~clk;

  spi_cmd_ram_v2 dut_a (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid[0]),
    .rx_ready (rx_ready[0]),
    .din      (din[0]),
    .dout     (dout[0]),
    .tx_valid (tx_valid[0]),
    .tx_ready (tx_ready[0]),
    .err      (err[0])
  );

  spi_cmd_ram_v2 #(
    .MEM_DEPTH (200),
    .AUTO_INC  (0)
  ) dut_b (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid[1]),
    .rx_ready (rx_ready[1]),
    .din      (din[1]),
    .dout     (dout[1]),
    .tx_valid (tx_valid[1]),
    .tx_ready (tx_ready[1]),
    .err      (err[1])
  );

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  // Monitor: err every cycle, read data on each handshake.
  always @(negedge clk) begin
    bit exp_e;
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        exp_e = (erp[d] != ewp[d]) &&
                (ed[d][erp[d] % 16] == ncyc);
        if (exp_e) erp[d]++;
        chk($sformatf("err%0d", d), 32'(err[d]), 32'(exp_e));
        if (tx_valid[d] && tx_ready[d]) begin
          if (rp[d] == wp[d]) begin
            checks++;
            failures++;
            $display("FAIL rd%0d unexpected actual=%0h required=none",
                     d, dout[d]);
          end else begin
            chk($sformatf("rd%0d_dout", d), 32'(dout[d]),
                32'(eq[d][rp[d] % 16]));
            rp[d]++;
          end
        end
      end
    end
    ncyc++;
  end

  task automatic send(
    input int         d,
    input logic [1:0] c,
    input logic [7:0] p,
    input bit         e
  );
    rx_valid[d] = 1'b1;
    din[d] = {c, p};
    @(posedge clk);
    #1;
    rx_valid[d] = 1'b0;
    if (e) begin
      ed[d][ewp[d] % 16] = ncyc;
      ewp[d]++;
    end
  endtask

  task automatic push_rd(input int d, input logic [7:0] v);
    eq[d][wp[d] % 16] = v;
    wp[d]++;
  endtask

  task automatic rd(input int d, input logic [7:0] v, input bit e);
    push_rd(d, v);
    send(d, 2'b11, 8'h00, e);
    chk("rd_latency", 32'(tx_valid[d]), 32'd1);
    tx_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    tx_ready[d] = 1'b0;
    chk("rd_valid_drop", 32'(tx_valid[d]), 32'd0);
    chk("rd_ready_back", 32'(rx_ready[d]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rx_valid[d] = 1'b0;
      din[d] = '0;
      tx_ready[d] = 1'b0;
      wp[d] = 0;
      rp[d] = 0;
      ewp[d] = 0;
      erp[d] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rx_ready_a", 32'(rx_ready[0]), 32'd0);
    chk("rst_rx_ready_b", 32'(rx_ready[1]), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid[0]), 32'd0);
    chk("rst_dout", 32'(dout[0]), 32'd0);
    chk("rst_err", 32'(err[0]), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    #1;
    chk("post_rst_ready", 32'(rx_ready[0]), 32'd1);

    // basic write then read
    send(0, 2'b00, 8'h05, 0);
    send(0, 2'b01, 8'hA5, 0);
    send(0, 2'b10, 8'h05, 0);
    rd(0, 8'hA5, 0);

    // auto-increment wrap at the top of memory
    send(0, 2'b00, 8'hFE, 0);
    send(0, 2'b01, 8'h11, 0);
    send(0, 2'b01, 8'h22, 0);
    send(0, 2'b01, 8'h33, 0);
    send(0, 2'b10, 8'hFE, 0);
    rd(0, 8'h11, 0);
    rd(0, 8'h22, 0);
    rd(0, 8'h33, 0);

    // back-pressure: hold 5 clocks, dropped write during hold
    send(0, 2'b00, 8'h05, 0);
    send(0, 2'b10, 8'h05, 0);
    push_rd(0, 8'hA5);
    send(0, 2'b11, 8'h00, 0);
    rx_valid[0] = 1'b1;
    din[0] = {2'b01, 8'hEE};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(tx_valid[0]), 32'd1);
      chk("hold_ready", 32'(rx_ready[0]), 32'd0);
      chk("hold_dout", 32'(dout[0]), 32'hA5);
    end
    tx_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    tx_ready[0] = 1'b0;
    rx_valid[0] = 1'b0;
    chk("bp_valid_drop", 32'(tx_valid[0]), 32'd0);
    chk("bp_ready_back", 32'(rx_ready[0]), 32'd1);
    chk("bp_dout_kept", 32'(dout[0]), 32'hA5);
    send(0, 2'b10, 8'h05, 0);
    rd(0, 8'hA5, 0);

    // out-of-range on depth 200
    send(1, 2'b00, 8'hC8, 0);
    send(1, 2'b01, 8'h7E, 1);
    send(1, 2'b01, 8'h7F, 1);
    send(1, 2'b10, 8'hC8, 0);
    rd(1, 8'h00, 1);
    send(1, 2'b00, 8'hC7, 0);
    send(1, 2'b01, 8'h5A, 0);
    send(1, 2'b10, 8'hC7, 0);
    rd(1, 8'h5A, 0);

    // static addresses, read right after write
    send(1, 2'b00, 8'h10, 0);
    send(1, 2'b10, 8'h10, 0);
    send(1, 2'b01, 8'h01, 0);
    send(1, 2'b01, 8'h02, 0);
    rd(1, 8'h02, 0);
    rd(1, 8'h02, 0);
    send(1, 2'b10, 8'hC7, 0);
    rd(1, 8'h5A, 0);

    // reset during a held read discards it
    send(0, 2'b10, 8'h05, 0);
    send(0, 2'b11, 8'h00, 0);
    chk("pre_rst_valid", 32'(tx_valid[0]), 32'd1);
    rst = 1'b1;
    rx_valid[0] = 1'b1;
    din[0] = {2'b00, 8'h33};
    #1;
    chk("rst_ready_comb", 32'(rx_ready[0]), 32'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_valid", 32'(tx_valid[0]), 32'd0);
    chk("mid_rst_dout", 32'(dout[0]), 32'd0);
    chk("mid_rst_ready", 32'(rx_ready[0]), 32'd0);
    rx_valid[0] = 1'b0;
    rst = 1'b0;
    #1;
    send(0, 2'b10, 8'hFE, 0);
    rd(0, 8'h11, 0);
    send(0, 2'b10, 8'h05, 0);
    rd(0, 8'hA5, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("rdq_a_drained", 32'(rp[0]), 32'(wp[0]));
    chk("rdq_b_drained", 32'(rp[1]), 32'(wp[1]));
    chk("errq_a_drained", 32'(erp[0]), 32'(ewp[0]));
    chk("errq_b_drained", 32'(erp[1]), 32'(ewp[1]));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
